pc_ifid_stage: RTL and testbench
================================

// Module: pc_ifid_stage
// PURPOSE
// - Front end of the in-order RISC-V-style pipeline: program counter (PC) plus IF/ID pipeline register.
// - Drives the fetch address to a combinational instruction memory and samples the returned word.
// - Passes instruction and PC to decode; obeys the global hold/flush bus and redirects on jumps.
// PARAMETERS
// - ADDR_W    32            instruction address width (`inst_addr_bus)
// - INST_W    32            instruction width (`inst_bus)
// - RST_PC    32'h00000000  PC value after reset
// - NOP_INST  32'h00000013  bubble inserted on flush/reset (addi x0,x0,0)
// PORTS
// - clk           in   1       single clock, all state updates on rising edge
// - rst_n         in   1       reset: synchronous, active-high (1 = reset), sampled on clk rising edge
// - inst_i        in   32      instruction word for inst_addr_o (combinational memory read)
// - inst_addr_o   out  32      current PC / fetch address
// - jump_flag_i   in   1       `jump_enable (1) = redirect PC; `jump_disable (0) = none
// - jump_addr_i   in   32      redirect target
// - hold_i        in   8       `hold_ctrl_bus: 4 fields x 2 bits; field k = hold_i[2k+1:2k]
// - ifid_inst_o   out  32      registered instruction to decode
// - ifid_addr_o   out  32      registered PC of ifid_inst_o
// - ifid_valid_o  out  1       1 = ifid_inst_o is a real fetched instruction, 0 = bubble
// BEHAVIOUR
// - Hold encoding (shared): `hold_no=2'b00, `hold_wait=2'b01, `hold_flush=2'b10; 2'b11 reserved, treated as `hold_no.
// - Field 0 = PC stage, field 1 = IF/ID, fields 2-3 = ID/EX, EX/MEM (ignored here).
// - PC register, priority high->low each rising edge:
//   1. rst_n=1 -> RST_PC
//   2. jump_flag_i=1 -> jump_addr_i (overrides any wait/flush on field 0)
//   3. field0=`hold_wait -> PC unchanged
//   4. else (no/flush/reserved) -> PC+4, modulo 2^32 (0xFFFFFFFC wraps to 0)
// - jump_addr_i used verbatim; no alignment check or masking.
// - IF/ID register, priority high->low:
//   1. rst_n=1 -> inst=NOP_INST, addr=0, valid=0
//   2. field1=`hold_flush -> inst=NOP_INST, addr=0, valid=0
//   3. field1=`hold_wait -> all unchanged
//   4. else -> inst=inst_i, addr=inst_addr_o (pre-update PC), valid=1
// - Latency: instruction at PC=A appears on ifid_* one cycle after inst_addr_o=A.
// - inst_addr_o is the PC register directly, no combinational path from inputs.
// - Jump with field1=`hold_flush: next cycle PC=target, IF/ID holds bubble; target instruction reaches IF/ID one cycle later.
// - Wait on field0 but not field1: IF/ID re-samples the same inst_i (duplicate fetch); the hazard unit must hold both fields together; no internal interlock.
// - Reset asserted mid-run takes effect at the next edge, overriding jump/hold.
// STRUCTURE
// - Shared defines package: inst_addr_bus, inst_bus, hold_ctrl_bus, hold_no/wait/flush, jump_enable/disable, NOP encoding.
// - One natural sub-module: pc_reg (PC register + next-PC mux); IF/ID register in top.
// - No FSM; two independent registered stages.
// TESTING
// - Reset 2 cycles, release -> inst_addr_o = 0,4,8,... per cycle; ifid_addr_o trails by one cycle, ifid_valid_o=1.
// - hold_i={flush,wait,wait,wait} for 2 cycles -> PC and IF/ID frozen; {4{no}} resumes from the same PC.
// - hold_i={no,flush,flush,flush}, jump_flag_i=1, jump_addr_i=0x100 -> next PC=0x100, IF/ID=NOP_INST, valid=0; next cycle IF/ID=mem[0x100], PC=0x104.
// - Jump with field0=wait -> PC still loads target (jump wins).
// - PC forced to 0xFFFFFFFC via jump -> following cycle PC=0x00000000.
// - rst_n=1 mid-stream with jump_flag_i=1 -> PC=0, IF/ID=NOP_INST, valid=0 at next edge.

Source files
------------

// File: rtl/pc_ifid_stage_pkg.sv
// Shared fetch-stage definitions: bus widths, hold/jump encodings and the NOP bubble.
package pc_ifid_stage_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;
  localparam int unsigned HOLD_W      = 8;

  localparam logic JUMP_ENABLE  = 1'b1;
  localparam logic JUMP_DISABLE = 1'b0;

  localparam logic [INST_W-1:0] NOP_ENC = 32'h0000_0013;

  // 2'b11 is reserved and behaves like HOLD_NO wherever it is decoded.
  typedef enum logic [1:0] {
    HOLD_NO    = 2'b00,
    HOLD_WAIT  = 2'b01,
    HOLD_FLUSH = 2'b10,
    HOLD_RSVD  = 2'b11
  } hold_e;

  // Global hold/flush bus, one field per pipeline stage (field 0 in the LSBs).
  typedef struct packed {
    hold_e exmem;
    hold_e idex;
    hold_e ifid;
    hold_e pc;
  } hold_bus_t;

endpackage

// File: rtl/pc_ifid_stage_pc_reg.sv
// Program counter with next-PC select: jump target, hold, or sequential PC+4.
module pc_ifid_stage_pc_reg
  import pc_ifid_stage_pkg::*;
#(
  parameter int unsigned       ADDR_W = INST_ADDR_W,
  parameter logic [ADDR_W-1:0] RST_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_flag,
  input  logic [ADDR_W-1:0] jump_addr,
  input  hold_e             hold,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_next_c;

  // A jump beats a wait on this stage; PC+4 wraps naturally at 2^ADDR_W.
  always_comb begin
    pc_next_c = pc + ADDR_W'(4);
    if (jump_flag == JUMP_ENABLE) begin
      pc_next_c = jump_addr;
    end else if (hold == HOLD_WAIT) begin
      pc_next_c = pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RST_PC;
    end else begin
      pc <= pc_next_c;
    end
  end

endmodule

// File: rtl/pc_ifid_stage.sv
// Pipeline front end: PC drives the instruction memory, IF/ID register captures word + PC for decode.
module pc_ifid_stage
  import pc_ifid_stage_pkg::*;
#(
  parameter int unsigned       ADDR_W   = INST_ADDR_W,
  parameter int unsigned       INST_W   = 32,
  parameter logic [ADDR_W-1:0] RST_PC   = '0,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_ENC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INST_W-1:0] inst_i,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic [HOLD_W-1:0] hold_i,
  output logic [INST_W-1:0] ifid_inst_o,
  output logic [ADDR_W-1:0] ifid_addr_o,
  output logic              ifid_valid_o
);

  hold_bus_t hold;
  logic      unused_hold;

  assign hold        = hold_bus_t'(hold_i);
  assign unused_hold = ^{hold.idex, hold.exmem};

  pc_ifid_stage_pc_reg #(
    .ADDR_W (ADDR_W),
    .RST_PC (RST_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst_n),
    .jump_flag (jump_flag_i),
    .jump_addr (jump_addr_i),
    .hold      (hold.pc),
    .pc        (inst_addr_o)
  );

  // IF/ID register: flush inserts a bubble, wait freezes, otherwise capture fetch.
  always_ff @(posedge clk) begin
    if (rst_n || (hold.ifid == HOLD_FLUSH)) begin
      ifid_inst_o  <= NOP_INST;
      ifid_addr_o  <= '0;
      ifid_valid_o <= 1'b0;
    end else if (hold.ifid != HOLD_WAIT) begin
      ifid_inst_o  <= inst_i;
      ifid_addr_o  <= inst_addr_o;
      ifid_valid_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_ifid_stage.sv
// Scoreboard bench for pc_ifid_stage: each step pushes the expected PC and IF/ID contents, then pops after the edge.
module tb_pc_ifid_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] addr;
    logic        valid;
  } obs_t;

  typedef struct packed {
    logic        rst;
    logic        jf;
    logic [31:0] ja;
    logic [7:0]  hold;
    obs_t        e;
  } step_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_o;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic [7:0]  hold_i;
  logic [31:0] ifid_inst_o;
  logic [31:0] ifid_addr_o;
  logic        ifid_valid_o;

  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  assign inst_i = mem(inst_addr_o);

  pc_ifid_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst_i       (inst_i),
    .inst_addr_o  (inst_addr_o),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .hold_i       (hold_i),
    .ifid_inst_o  (ifid_inst_o),
    .ifid_addr_o  (ifid_addr_o),
    .ifid_valid_o (ifid_valid_o)
  );

  function automatic step_t mk(input logic rst, input logic jf, input logic [31:0] ja,
                               input logic [7:0] hold, input logic [31:0] pc,
                               input logic [31:0] inst, input logic [31:0] addr,
                               input logic valid);
    step_t s;
    s.rst = rst; s.jf = jf; s.ja = ja; s.hold = hold;
    s.e.pc = pc; s.e.inst = inst; s.e.addr = addr; s.e.valid = valid;
    return s;
  endfunction

  // Drive one step's inputs and advance past the next rising edge.
  task automatic tick(input step_t s);
    rst_n       = s.rst;
    jump_flag_i = s.jf;
    jump_addr_i = s.ja;
    hold_i      = s.hold;
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.pc = inst_addr_o; o.inst = ifid_inst_o; o.addr = ifid_addr_o; o.valid = ifid_valid_o;
    return o;
  endfunction

  task automatic test_reset();
    obs_t e, g;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(1, 0, 0, 8'h00, 0, NOP, 0, 0).e);
      tick(mk(1, 0, 0, 8'h00, 0, 0, 0, 0));
      g = sample(); e = exp_q.pop_front(); n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL reset[%0d] got pc=%h inst=%h addr=%h v=%b want pc=%h inst=%h addr=%h v=%b",
                 i, g.pc, g.inst, g.addr, g.valid, e.pc, e.inst, e.addr, e.valid);
      end
    end
  endtask

  task automatic test_sequential();
    obs_t e, g;
    step_t s;
    for (int k = 1; k <= 5; k++) begin
      s = mk(0, 0, 0, 8'h00, 32'(4 * k), mem(32'(4 * (k - 1))), 32'(4 * (k - 1)), 1);
      exp_q.push_back(s.e);
      tick(s);
      g = sample(); e = exp_q.pop_front(); n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL sequential[%0d] got pc=%h inst=%h addr=%h v=%b want pc=%h inst=%h addr=%h v=%b",
                 k, g.pc, g.inst, g.addr, g.valid, e.pc, e.inst, e.addr, e.valid);
      end
    end
  endtask

  // {flush,wait,wait,wait}: both PC and IF/ID freeze, then resume from the same PC.
  task automatic test_hold_wait();
    step_t tbl[3];
    obs_t  e, g;
    tbl[0] = mk(0, 0, 0, 8'b10_01_01_01, 32'd20, mem(32'd16), 32'd16, 1);
    tbl[1] = mk(0, 0, 0, 8'b10_01_01_01, 32'd20, mem(32'd16), 32'd16, 1);
    tbl[2] = mk(0, 0, 0, 8'h00,          32'd24, mem(32'd20), 32'd20, 1);
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i].e);
      tick(tbl[i]);
      g = sample(); e = exp_q.pop_front(); n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL hold_wait[%0d] got pc=%h inst=%h addr=%h v=%b want pc=%h inst=%h addr=%h v=%b",
                 i, g.pc, g.inst, g.addr, g.valid, e.pc, e.inst, e.addr, e.valid);
      end
    end
  endtask

  task automatic test_jump_flush();
    step_t tbl[2];
    obs_t  e, g;
    tbl[0] = mk(0, 1, 32'h100, 8'b00_10_10_10, 32'h100, NOP,          32'h0,   0);
    tbl[1] = mk(0, 0, 32'h0,   8'h00,          32'h104, mem(32'h100), 32'h100, 1);
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i].e);
      tick(tbl[i]);
      g = sample(); e = exp_q.pop_front(); n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL jump_flush[%0d] got pc=%h inst=%h addr=%h v=%b want pc=%h inst=%h addr=%h v=%b",
                 i, g.pc, g.inst, g.addr, g.valid, e.pc, e.inst, e.addr, e.valid);
      end
    end
  endtask

  // Jump wins over a PC wait; a PC-only wait then re-samples the same word into IF/ID.
  task automatic test_jump_wait();
    step_t tbl[3];
    obs_t  e, g;
    tbl[0] = mk(0, 1, 32'h200, 8'b00_00_00_01, 32'h200, mem(32'h104), 32'h104, 1);
    tbl[1] = mk(0, 0, 32'h0,   8'b00_00_00_01, 32'h200, mem(32'h200), 32'h200, 1);
    tbl[2] = mk(0, 0, 32'h0,   8'b00_00_00_01, 32'h200, mem(32'h200), 32'h200, 1);
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i].e);
      tick(tbl[i]);
      g = sample(); e = exp_q.pop_front(); n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL jump_wait[%0d] got pc=%h inst=%h addr=%h v=%b want pc=%h inst=%h addr=%h v=%b",
                 i, g.pc, g.inst, g.addr, g.valid, e.pc, e.inst, e.addr, e.valid);
      end
    end
  endtask

  task automatic test_wrap();
    step_t tbl[3];
    obs_t  e, g;
    tbl[0] = mk(0, 1, 32'hFFFF_FFFC, 8'h00, 32'hFFFF_FFFC, mem(32'h200),        32'h200,        1);
    tbl[1] = mk(0, 0, 32'h0,         8'h00, 32'h0,         mem(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1);
    tbl[2] = mk(0, 0, 32'h0,         8'hFF, 32'h4,         mem(32'h0),         32'h0,         1);
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i].e);
      tick(tbl[i]);
      g = sample(); e = exp_q.pop_front(); n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL wrap[%0d] got pc=%h inst=%h addr=%h v=%b want pc=%h inst=%h addr=%h v=%b",
                 i, g.pc, g.inst, g.addr, g.valid, e.pc, e.inst, e.addr, e.valid);
      end
    end
  endtask

  // Jumps every cycle, then an IF/ID-only flush while the PC keeps advancing.
  task automatic test_back_to_back();
    step_t tbl[5];
    obs_t  e, g;
    tbl[0] = mk(0, 1, 32'h40, 8'h00,          32'h40, mem(32'h4),  32'h4,  1);
    tbl[1] = mk(0, 1, 32'h80, 8'h00,          32'h80, mem(32'h40), 32'h40, 1);
    tbl[2] = mk(0, 1, 32'hC0, 8'h00,          32'hC0, mem(32'h80), 32'h80, 1);
    tbl[3] = mk(0, 0, 32'h0,  8'b00_00_10_00, 32'hC4, NOP,         32'h0,  0);
    tbl[4] = mk(0, 0, 32'h0,  8'h00,          32'hC8, mem(32'hC4), 32'hC4, 1);
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i].e);
      tick(tbl[i]);
      g = sample(); e = exp_q.pop_front(); n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL back_to_back[%0d] got pc=%h inst=%h addr=%h v=%b want pc=%h inst=%h addr=%h v=%b",
                 i, g.pc, g.inst, g.addr, g.valid, e.pc, e.inst, e.addr, e.valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    step_t tbl[2];
    obs_t  e, g;
    tbl[0] = mk(1, 1, 32'h300, 8'b00_01_01_01, 32'h0, NOP,        32'h0, 0);
    tbl[1] = mk(0, 0, 32'h0,   8'h00,          32'h4, mem(32'h0), 32'h0, 1);
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i].e);
      tick(tbl[i]);
      g = sample(); e = exp_q.pop_front(); n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL reset_mid[%0d] got pc=%h inst=%h addr=%h v=%b want pc=%h inst=%h addr=%h v=%b",
                 i, g.pc, g.inst, g.addr, g.valid, e.pc, e.inst, e.addr, e.valid);
      end
    end
  endtask

  initial begin
    rst_n       = 1'b1;
    jump_flag_i = 1'b0;
    jump_addr_i = '0;
    hold_i      = '0;
    test_reset();
    test_sequential();
    test_hold_wait();
    test_jump_flush();
    test_jump_wait();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d entries want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
